// File: rtl/nanosoc_adp_pkg.sv
// ADP shared definitions: command byte codes and
// the stream arbiter state encoding.
package nanosoc_adp_pkg;

  localparam logic [7:0] ADP_ESC = 8'h1b;
  localparam logic [7:0] ADP_NL  = 8'h0a;

  localparam int ADP_MAX_SRC = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/nanosoc_rr_pick.sv
// Round-robin selector: first set request after
// the last grant, wrapping modulo N.
module nanosoc_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last,
  output logic [1:0]   idx,
  output logic         found
);

  // Walk distances far-to-near so the nearest
  // requester after last is the final write.
  always_comb begin
    idx   = last;
    found = 1'b0;
    for (int k = N; k >= 1; k--) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && (((int'(last) + k) % N) == i)) begin
          idx   = 2'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nanosoc_adp_stream_arbiter.sv
// Command-granular round-robin arbiter feeding the
// single ADP byte stream through a registered slice.
module nanosoc_adp_stream_arbiter
  import nanosoc_adp_pkg::*;
#(
  parameter int         NUM_SRC   = 2,
  parameter logic [7:0] TERM_BYTE = ADP_NL,
  parameter int         TIMEOUT   = 1024,
  parameter int         TO_W      = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic                 txd8_valid,
  output logic [7:0]           txd8_data,
  input  logic                 txd8_ready,
  output logic [1:0]           grant_id,
  output logic                 locked,
  output logic                 timeout_pulse
);

  if (NUM_SRC < 2 || NUM_SRC > ADP_MAX_SRC) begin : g_bad
    $error("NUM_SRC out of range");
  end

  arb_state_e      state;
  logic [TO_W-1:0] idle_cnt;
  logic [TO_W-1:0] idle_nxt;
  logic [1:0]      pick_idx;
  logic            pick_found;
  logic            can_load;
  logic            sel_valid;
  logic [7:0]      sel_data;
  logic            accept;
  logic            to_hit;

  nanosoc_rr_pick #(
    .N(NUM_SRC)
  ) u_pick (
    .req  (src_valid),
    .last (grant_id),
    .idx  (pick_idx),
    .found(pick_found)
  );

  assign locked   = (state == ARB_LOCKED);
  assign can_load = !txd8_valid || txd8_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 8'h00;
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == 2'(i)) begin
        sel_valid    = src_valid[i];
        sel_data     = src_data[8*i +: 8];
        src_ready[i] = locked && can_load;
      end
    end
  end

  assign accept   = locked && sel_valid && can_load;
  assign idle_nxt = idle_cnt + TO_W'(1);
  // TIMEOUT of zero never matches, so the lock is held forever.
  assign to_hit   = (TIMEOUT != 0) &&
                    (idle_nxt == TO_W'(TIMEOUT));

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      state         <= ARB_IDLE;
      grant_id      <= 2'(NUM_SRC - 1);
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
      txd8_valid    <= 1'b0;
      txd8_data     <= 8'h00;
    end else begin
      timeout_pulse <= 1'b0;
      if (accept) begin
        txd8_valid <= 1'b1;
        txd8_data  <= sel_data;
      end else if (txd8_valid && txd8_ready) begin
        txd8_valid <= 1'b0;
      end
      unique case (state)
        ARB_IDLE: begin
          idle_cnt <= '0;
          if (pick_found) begin
            state    <= ARB_LOCKED;
            grant_id <= pick_idx;
          end
        end
        ARB_LOCKED: begin
          if (accept) begin
            idle_cnt <= '0;
            if (sel_data == TERM_BYTE) begin
              state <= ARB_IDLE;
            end
          end else if (!sel_valid) begin
            if (to_hit) begin
              state         <= ARB_IDLE;
              timeout_pulse <= 1'b1;
              idle_cnt      <= '0;
            end else begin
              idle_cnt <= idle_nxt;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nanosoc_adp_stream_arbiter.sv
// Scoreboard bench for the ADP stream arbiter: drivers,
// output monitor and directed command scenarios.
module tb_nanosoc_adp_stream_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [1:0]  sv;
  logic [7:0]  sd [2];
  wire  [15:0] src_data = {sd[1], sd[0]};
  wire  [1:0]  src_ready;
  wire         txd8_valid;
  wire  [7:0]  txd8_data;
  logic        txd8_ready;
  wire  [1:0]  grant_id;
  wire         locked;
  wire         timeout_pulse;

  logic [1:0]  dv;
  logic [15:0] dd;
  wire  [1:0]  d_ready;
  wire         d_tv;
  wire  [7:0]  d_td;
  logic        d_tr = 1'b1;
  wire  [1:0]  d_gid;
  wire         d_lock;
  wire         d_pulse;

  int checks = 0;
  int errors = 0;
  logic bp_en;

  logic [7:0] exp_q [$];
  logic [1:0] gexp [$];
  logic [7:0] txq [2][$];

  always #5 aclk = ~aclk;

  nanosoc_adp_stream_arbiter #(
    .NUM_SRC(2), .TIMEOUT(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .src_valid(sv), .src_data(src_data),
    .src_ready(src_ready),
    .txd8_valid(txd8_valid), .txd8_data(txd8_data),
    .txd8_ready(txd8_ready),
    .grant_id(grant_id), .locked(locked),
    .timeout_pulse(timeout_pulse)
  );

  nanosoc_adp_stream_arbiter #(
    .NUM_SRC(2), .TIMEOUT(0)
  ) u_dis (
    .aclk(aclk), .aresetn(aresetn),
    .src_valid(dv), .src_data(dd),
    .src_ready(d_ready),
    .txd8_valid(d_tv), .txd8_data(d_td),
    .txd8_ready(d_tr),
    .grant_id(d_gid), .locked(d_lock),
    .timeout_pulse(d_pulse)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic push_src(input int src, input string s);
    for (int i = 0; i < s.len(); i++)
      txq[src].push_back(s[i]);
  endtask

  task automatic push_exp(input string s);
    for (int i = 0; i < s.len(); i++)
      exp_q.push_back(s[i]);
  endtask

  task automatic drive(input int g);
    logic f;
    forever begin
      @(negedge aclk);
      f = sv[g] && src_ready[g];
      @(posedge aclk);
      #1;
      if (f && txq[g].size() > 0)
        void'(txq[g].pop_front());
      if (txq[g].size() > 0) begin
        sv[g] = 1'b1;
        sd[g] = txq[g][0];
      end else begin
        sv[g] = 1'b0;
      end
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge aclk);
      #1;
      txd8_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic monitor();
    logic pv, pr, pl;
    logic [7:0] pd, e;
    logic [1:0] eg;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        pv = 1'b0;
        pl = 1'b0;
      end else begin
        if (pv && !pr) begin
          checks++;
          if (!txd8_valid || txd8_data !== pd) begin
            errors++;
            $display("FAIL hold: got v=%0b d=%02h, expected v=1 d=%02h",
                     txd8_valid, txd8_data, pd);
          end
        end
        if (txd8_valid && txd8_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_byte: got %02h, expected none",
                     txd8_data);
          end else begin
            e = exp_q.pop_front();
            if (e !== txd8_data) begin
              errors++;
              $display("FAIL byte: got %02h, expected %02h",
                       txd8_data, e);
            end
          end
        end
        if (locked && !pl) begin
          checks++;
          if (gexp.size() == 0) begin
            errors++;
            $display("FAIL grant: got %0d, expected none", grant_id);
          end else begin
            eg = gexp.pop_front();
            if (eg !== grant_id) begin
              errors++;
              $display("FAIL grant: got %0d, expected %0d",
                       grant_id, eg);
            end
          end
        end
        pv = txd8_valid; pr = txd8_ready;
        pd = txd8_data;  pl = locked;
      end
    end
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || txq[0].size() != 0 ||
            txq[1].size() != 0) && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    chk({nm, "_left"}, 32'(exp_q.size()), 0);
    repeat (4) @(negedge aclk);
    chk({nm, "_grants_left"}, 32'(gexp.size()), 0);
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b0;
  endtask

  initial begin
    int n, bub;
    bit started;
    string s_a;
    logic [7:0] b;
    s_a = "A 20000000\n";
    sv = 2'b00; sd[0] = 8'h00; sd[1] = 8'h00;
    dv = 2'b00; dd = 16'h0000;
    txd8_ready = 1'b1; bp_en = 1'b0;
    #1 aresetn = 1'b1;
    #2;
    chk("rst_valid", 32'(txd8_valid), 0);
    chk("rst_data", 32'(txd8_data), 0);
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_grant", 32'(grant_id), 1);
    chk("rst_pulse", 32'(timeout_pulse), 0);
    fork
      drive(0);
      drive(1);
      drive_ready();
      monitor();
    join_none
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b0;

    // single source, latency and release
    @(posedge aclk); #2;
    push_src(0, s_a); push_exp(s_a); gexp.push_back(0);
    @(posedge aclk);
    @(negedge aclk);
    chk("c0_ready", 32'(src_ready[0]), 0);
    chk("c0_valid", 32'(txd8_valid), 0);
    @(negedge aclk);
    chk("c1_ready", 32'(src_ready[0]), 1);
    chk("c1_valid", 32'(txd8_valid), 0);
    @(negedge aclk);
    chk("c2_valid", 32'(txd8_valid), 1);
    chk("c2_data", 32'(txd8_data), 32'h41);
    n = 0;
    while (!(txd8_valid && txd8_data == 8'h0a) && n < 50) begin
      @(negedge aclk); n++;
    end
    chk("term_locked", 32'(locked), 0);
    wait_drain("single");

    // contention, alternating grants
    do_reset();
    @(posedge aclk); #2;
    push_src(0, "C1\nC1\n"); push_src(1, "C2\nC2\n");
    push_exp("C1\nC2\nC1\nC2\n");
    gexp.push_back(0); gexp.push_back(1);
    gexp.push_back(0); gexp.push_back(1);
    started = 0; bub = 0; n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge aclk); #1;
      if (txd8_valid) started = 1;
      else if (started) bub++;
      n++;
    end
    chk("bubbles", 32'(bub), 3);
    wait_drain("contention");

    // backpressure, 64 bytes
    @(posedge aclk); #2;
    for (int k = 0; k < 64; k++) begin
      b = (k == 63) ? 8'h0a : 8'(8'h30 + k);
      txq[0].push_back(b);
      exp_q.push_back(b);
    end
    gexp.push_back(0);
    bp_en = 1'b1;
    wait_drain("backpressure");
    bp_en = 1'b0;

    // timeout release hands over to waiting source
    @(posedge aclk); #2;
    push_src(1, "R"); push_src(0, "W\n");
    push_exp("RW\n");
    gexp.push_back(1); gexp.push_back(0);
    n = 0;
    while (!(txd8_valid && txd8_data == 8'h52) && n < 50) begin
      @(negedge aclk); n++;
    end
    chk("to_r_seen", 32'(n < 50), 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge aclk);
      chk("to_pulse", 32'(timeout_pulse), 32'(k == 8));
    end
    chk("to_released", 32'(locked), 0);
    @(negedge aclk);
    chk("to_relock", 32'(locked), 1);
    chk("to_regrant", 32'(grant_id), 0);
    chk("to_pulse_off", 32'(timeout_pulse), 0);
    wait_drain("timeout");

    // reset in the middle of a command
    @(posedge aclk); #2;
    push_src(1, "abcdefghi\n"); push_exp("abcdefghi\n");
    gexp.push_back(1);
    n = 0;
    while (!(txd8_valid && txd8_data == 8'h65) && n < 50) begin
      @(negedge aclk); n++;
    end
    chk("mid_e_seen", 32'(n < 50), 1);
    #1 aresetn = 1'b1;
    #1;
    chk("mid_valid", 32'(txd8_valid), 0);
    chk("mid_data", 32'(txd8_data), 0);
    chk("mid_locked", 32'(locked), 0);
    chk("mid_grant", 32'(grant_id), 1);
    chk("mid_ready", 32'(src_ready), 0);
    exp_q.delete(); gexp.delete(); txq[1].delete();
    @(posedge aclk);
    #1 aresetn = 1'b0;
    @(posedge aclk); #2;
    push_src(0, "P\n"); push_src(1, "Q\n");
    push_exp("P\nQ\n");
    gexp.push_back(0); gexp.push_back(1);
    wait_drain("after_reset");

    // timeout disabled: lock held indefinitely
    @(posedge aclk); #2;
    dv = 2'b01; dd = 16'h0058;
    n = 0;
    while (!d_ready[0] && n < 20) begin
      @(negedge aclk); n++;
    end
    chk("dis_ready", 32'(d_ready[0]), 1);
    @(posedge aclk); #1 dv = 2'b00;
    @(negedge aclk);
    chk("dis_valid", 32'(d_tv), 1);
    chk("dis_data", 32'(d_td), 32'h58);
    n = 0;
    repeat (5000) begin
      @(negedge aclk);
      if (!d_lock || d_pulse) n++;
    end
    chk("dis_bad_cycles", 32'(n), 0);
    chk("dis_grant", 32'(d_gid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
